fetch_buffer: RTL and testbench
===============================

# fetch_buffer

Instruction fetch stage that produces the `Instruction` / `PC_plus_two` stream consumed by `decode`, and accepts `decode`'s branch/jump redirect in return. It owns the PC register, issues single-outstanding reads to a variable-latency instruction memory, and holds returned instructions in a small FIFO. Flushes on redirect, stops on halt, and presents a NOP to decode whenever no valid instruction is available.

## Interface
Parameters:
- `DEPTH`, 2: FIFO entries; power of two, ≥2.
- `RESET_PC`, 16'h0000: PC loaded on reset.

Ports (one clock; reset is asynchronous and active-low):
- `clk` in 1: system clock.
- `rst` in 1: asynchronous, active-low master reset.
- `imem_addr` out 16: read address; always equals the PC register.
- `imem_rd` out 1: read request.
- `imem_stall` in 1: memory rejects this cycle's request.
- `imem_done` in 1: read data valid.
- `imem_data` in 16: returned instruction.
- `Instruction` out 16: instruction to decode; 16'h0800 (NOP) when `inst_valid`=0.
- `PC_plus_two` out 16: address+2 of `Instruction`; 16'h0000 when invalid.
- `inst_valid` out 1: head entry valid.
- `dstall` in 1: decode not accepting this cycle.
- `branchJumpDTaken` in 1: redirect from decode.
- `branchJumpDTarget` in 16: redirect PC.
- `halt` in 1: halt decoded; stops fetch.
- `err` out 1: protocol error (sticky).

## Operation
- Request accepted when `imem_rd`=1 and `imem_stall`=0: PC ← PC+2 (16-bit wrap, 16'hFFFE→0), `outstanding` ← 1, `req_ppt` ← PC+2.
- `imem_done`=1 ends outstanding. If not squashed, push {`imem_data`, `req_ppt`}; if squashed, drop and clear `squash`.
- `imem_rd` = !`halted` & !`branchJumpDTaken` & (!`outstanding` | `imem_done`) & (count − pop + (`outstanding` & !`squash`)) < DEPTH. Back-to-back request in the cycle the previous one completes is allowed.
- Pop when `inst_valid` & !`dstall`. Push and pop in the same cycle: count unchanged.
- Redirect (`branchJumpDTaken`=1): at the edge, FIFO flushed (count←0), PC ← target, `squash` ← `outstanding` & !`imem_done`. No request that cycle. Any pop that cycle is discarded.
- Halt: `halted` latches at the edge where `halt`=1 and clears only on reset. No new requests after latch; the outstanding read still completes and is pushed; FIFO drains normally. A redirect in the same cycle still flushes and loads PC.
- `err` set on `imem_done` with no outstanding request, or on a push into a full FIFO; sticky until reset.

## Timing
- Reset (async assert, synchronous release at next edge): PC=`RESET_PC`, count=0, `outstanding`=0, `squash`=0, `halted`=0, `err`=0. Therefore `imem_rd`=1, `imem_addr`=`RESET_PC`, `inst_valid`=0, `Instruction`=16'h0800, `PC_plus_two`=0.
- Reset mid-read: state clears immediately; a later `imem_done` with no outstanding request sets `err`.
- Minimum latency from `imem_done` to `inst_valid`: 1 cycle without bypass, 0 with bypass.
- Full FIFO: `imem_rd`=0 until a pop frees space. Empty FIFO: NOP output.
- Redirect target visible on `imem_addr` the cycle after redirect. The first request issues that cycle, or in the cycle the squashed read's `imem_done` arrives.

## Configuration
- `FETCH_BYPASS_EN` defined:
  - With count=0, `imem_done`=1 and not squashed, outputs show `imem_data` / `req_ppt` with `inst_valid`=1 in the same cycle.
  - If `dstall`=0, the word is consumed and not pushed; otherwise it is pushed.
  - Redirect the same cycle: bypass output is shown but discarded.
- Undefined: returned data always goes through the FIFO.

## Test plan
- Reset, memory done 1 cycle after each request, `dstall`=0 → requests at 0,2,4,…; decode sees `PC_plus_two`=2,4,6 in order. No-bypass first `inst_valid` is 2 cycles after reset release.
- `dstall`=1 held, DEPTH=2 → exactly 2 pushes, `imem_rd`=0 with no outstanding read. Release `dstall` → fetch resumes at PC=4.
- Redirect to 16'h0100 while a read to 16'h0006 is outstanding → that data is dropped, FIFO empty, next `imem_addr`=16'h0100, next delivered `PC_plus_two`=16'h0102.
- `imem_stall`=1 for 3 cycles on address 16'h0010 → PC holds 16'h0010, no push. After the stall, the instruction is delivered with `PC_plus_two`=16'h0012.
- `halt` pulsed with one read outstanding and 1 entry queued → both delivered, then `imem_rd` stays 0 and `inst_valid`=0 with NOP.
- `imem_done` asserted with no outstanding request → `err`=1 next cycle; stays 1 until `rst`=0.

Source files
------------

// File: rtl/fetch_buffer_if.sv
// Fetch stage bus: instruction memory port and decode-facing stream.
// master = fetch stage, slave = memory/decode side.
interface fetch_buffer_if;
  logic [15:0] imem_addr;
  logic        imem_rd;
  logic        imem_stall;
  logic        imem_done;
  logic [15:0] imem_data;
  logic [15:0] Instruction;
  logic [15:0] PC_plus_two;
  logic        inst_valid;
  logic        dstall;
  logic        branchJumpDTaken;
  logic [15:0] branchJumpDTarget;
  logic        halt;
  logic        err;

  modport master (
    output imem_addr, imem_rd,
    output Instruction, PC_plus_two,
    output inst_valid, err,
    input  imem_stall, imem_done, imem_data,
    input  dstall, branchJumpDTaken,
    input  branchJumpDTarget, halt
  );

  modport slave (
    input  imem_addr, imem_rd,
    input  Instruction, PC_plus_two,
    input  inst_valid, err,
    output imem_stall, imem_done, imem_data,
    output dstall, branchJumpDTaken,
    output branchJumpDTarget, halt
  );
endinterface

// File: rtl/fetch_buffer.sv
// Fetch stage: PC, single-outstanding imem reads, small FIFO.
// Define FETCH_BYPASS_EN to forward returning data when FIFO empty.
module fetch_buffer #(
  parameter int          DEPTH    = 2,
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input logic            clk,
  input logic            rst,
  fetch_buffer_if.master bus
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [15:0] inst;
    logic [15:0] ppt;
  } entry_t;

  entry_t          mem [DEPTH];
  logic [15:0]     pc;
  logic [15:0]     req_ppt;
  logic [CW-1:0]   count;
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic            outstanding;
  logic            squash;
  logic            halted;
  logic            err_q;

  logic            redir;
  logic            done;
  logic            live_done;
  logic            byp;
  logic            valid;
  logic            pop;
  logic            fifo_pop;
  logic            push;
  logic            full;
  logic            push_ok;
  logic [CW:0]     occ;
  logic            rd;
  logic            accept;
  logic [15:0]     head_inst;
  logic [15:0]     head_ppt;

  assign redir     = bus.branchJumpDTaken;
  assign done      = bus.imem_done;
  assign live_done = done & outstanding & !squash;

`ifdef FETCH_BYPASS_EN
  assign byp = live_done & (count == '0);
`else
  assign byp = 1'b0;
`endif

  assign valid    = (count != '0) | byp;
  assign pop      = valid & !bus.dstall;
  assign fifo_pop = pop & !byp;
  assign push     = live_done & !(byp & !bus.dstall);
  assign full     = count == CW'(DEPTH);
  assign push_ok  = push & (!full | fifo_pop);

  // occupancy after this cycle, counting the read in flight
  assign occ = {1'b0, count}
             + (CW+1)'(outstanding & !squash)
             - (CW+1)'(pop);

  assign rd = !halted & !redir
            & (!outstanding | done)
            & (occ < (CW+1)'(DEPTH));
  assign accept = rd & !bus.imem_stall;

  assign head_inst = byp ? bus.imem_data : mem[rd_ptr].inst;
  assign head_ppt  = byp ? req_ppt : mem[rd_ptr].ppt;

  assign bus.imem_addr   = pc;
  assign bus.imem_rd     = rd;
  assign bus.inst_valid  = valid;
  assign bus.Instruction = valid ? head_inst : 16'h0800;
  assign bus.PC_plus_two = valid ? head_ppt : 16'h0000;
  assign bus.err         = err_q;

  // FIFO storage write
  always_ff @(posedge clk) begin
    if (push_ok && !redir) begin
      mem[wr_ptr] <= '{inst: bus.imem_data, ppt: req_ppt};
    end
  end

  // PC, request tracking, FIFO pointers and status flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      req_ppt     <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      outstanding <= 1'b0;
      squash      <= 1'b0;
      halted      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      halted <= halted | bus.halt;
      err_q  <= err_q
              | (done & !outstanding)
              | (push & full & !fifo_pop);
      if (redir) begin
        pc     <= bus.branchJumpDTarget;
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
        squash <= outstanding & !done;
        if (done) begin
          outstanding <= 1'b0;
        end
      end else begin
        if (accept) begin
          pc          <= pc + 16'd2;
          req_ppt     <= pc + 16'd2;
          outstanding <= 1'b1;
        end else if (done) begin
          outstanding <= 1'b0;
        end
        if (done) begin
          squash <= 1'b0;
        end
        if (push_ok) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (fifo_pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count + CW'(push_ok) - CW'(fifo_pop);
      end
    end
  end

endmodule

// File: tb/tb_fetch_buffer.sv
// Bench for fetch_buffer: directed scenarios plus random traffic
// against a stream-level model of the expected fetch sequence.
module tb_fetch_buffer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fetch_buffer_if bus ();

  fetch_buffer #(
    .DEPTH    (2),
    .RESET_PC (16'h0000)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

`ifdef FETCH_BYPASS_EN
  localparam int EXP_FIRST = 1;
`else
  localparam int EXP_FIRST = 2;
`endif

  int errors = 0;
  int checks = 0;

  logic [15:0] exp_req;
  logic [15:0] exp_ppt;
  logic [15:0] last_ppt;
  logic        exp_err;
  logic        req_out;
  logic        mem_busy;
  logic [15:0] mem_addr;
  logic        force_done;
  int          mem_lat;
  int          lat_lo;
  int          lat_hi;
  int          delivered;
  int          accepts;
  int          cyc_idx;
  int          first_valid;

  function automatic logic [15:0] word(input logic [15:0] a);
    return (a ^ 16'h5A5A) + 16'h1357;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic stl, input logic ds,
                     input logic bj, input logic [15:0] tgt,
                     input logic hlt);
    bus.imem_done = (mem_busy && mem_lat == 0) || force_done;
    bus.imem_data = word(mem_addr);
    bus.imem_stall = stl;
    bus.dstall = ds;
    bus.branchJumpDTaken = bj;
    bus.branchJumpDTarget = tgt;
    bus.halt = hlt;
    #1;
    chk("imem_addr", bus.imem_addr, exp_req);
    chk("err", bus.err, exp_err);
    if (bj) chk("rd_on_redirect", bus.imem_rd, 0);
    if (!bus.inst_valid) begin
      chk("nop_inst", bus.Instruction, 16'h0800);
      chk("nop_ppt", bus.PC_plus_two, 0);
    end else begin
      if (first_valid < 0) first_valid = cyc_idx;
      if (!ds && !bj) begin
        chk("ppt", bus.PC_plus_two, exp_ppt);
        chk("inst", bus.Instruction, word(exp_ppt - 16'd2));
        last_ppt = exp_ppt;
        exp_ppt = exp_ppt + 16'd2;
        delivered++;
      end
    end
    if (bus.imem_done && !req_out) exp_err = 1'b1;
    if (bus.imem_done) begin
      mem_busy = 1'b0;
      req_out = 1'b0;
    end else if (mem_busy) begin
      mem_lat--;
    end
    if (bj) begin
      exp_req = tgt;
      exp_ppt = tgt + 16'd2;
    end else if (bus.imem_rd && !stl) begin
      accepts++;
      exp_req = exp_req + 16'd2;
      mem_busy = 1'b1;
      req_out = 1'b1;
      mem_addr = bus.imem_addr;
      mem_lat = int'($urandom_range(lat_hi, lat_lo));
    end
    @(posedge clk);
    #1;
    cyc_idx++;
  endtask

  task automatic do_reset(input logic keep_mem);
    rst = 1'b0;
    force_done = 1'b0;
    bus.imem_done = 1'b0;
    bus.imem_stall = 1'b0;
    bus.dstall = 1'b0;
    bus.branchJumpDTaken = 1'b0;
    bus.halt = 1'b0;
    #2;
    chk("rst_rd", bus.imem_rd, 1);
    chk("rst_addr", bus.imem_addr, 16'h0000);
    chk("rst_valid", bus.inst_valid, 0);
    chk("rst_inst", bus.Instruction, 16'h0800);
    chk("rst_ppt", bus.PC_plus_two, 0);
    chk("rst_err", bus.err, 0);
    rst = 1'b1;
    #1;
    exp_req = 16'h0000;
    exp_ppt = 16'h0002;
    exp_err = 1'b0;
    req_out = 1'b0;
    if (!keep_mem) mem_busy = 1'b0;
    cyc_idx = 0;
    first_valid = -1;
    accepts = 0;
    delivered = 0;
  endtask

  initial begin
    int d0;
    logic        r_stl;
    logic        r_ds;
    logic        r_bj;
    logic [15:0] r_tgt;
    mem_busy = 1'b0;
    mem_addr = '0;
    mem_lat = 0;
    last_ppt = '0;
    force_done = 1'b0;
    bus.imem_data = '0;
    bus.branchJumpDTarget = '0;
    lat_lo = 0;
    lat_hi = 0;
    @(posedge clk);
    #1;

    // streaming, memory answers one cycle after each request
    do_reset(1'b0);
    repeat (10) cyc(0, 0, 0, 16'h0, 0);
    chk("first_valid_latency", first_valid, EXP_FIRST);
    chk("stream_progress", delivered >= 8, 1);

    // decode held off: FIFO fills, fetch stops
    do_reset(1'b0);
    repeat (8) cyc(0, 1, 0, 16'h0, 0);
    chk("hold_accepts", accepts, 2);
    chk("hold_rd", bus.imem_rd, 0);
    chk("hold_pc", bus.imem_addr, 16'h0004);
    chk("hold_valid", bus.inst_valid, 1);
    repeat (6) cyc(0, 0, 0, 16'h0, 0);
    chk("hold_resume", delivered >= 3, 1);

    // redirect while read to 0006 is outstanding
    do_reset(1'b0);
    lat_lo = 3;
    lat_hi = 3;
    for (int i = 0; i < 40; i++) begin
      if (mem_busy && req_out && mem_addr == 16'h0006) break;
      cyc(0, 0, 0, 16'h0, 0);
    end
    chk("reach_0006", mem_addr, 16'h0006);
    cyc(0, 0, 1, 16'h0100, 0);
    chk("redir_addr", bus.imem_addr, 16'h0100);
    chk("redir_empty", bus.inst_valid, 0);
    d0 = delivered;
    for (int i = 0; i < 40; i++) begin
      if (delivered != d0) break;
      cyc(0, 0, 0, 16'h0, 0);
    end
    chk("redir_first", last_ppt, 16'h0102);

    // memory stall on 0010
    do_reset(1'b0);
    lat_lo = 0;
    lat_hi = 0;
    for (int i = 0; i < 40; i++) begin
      if (bus.imem_addr == 16'h0010) break;
      cyc(0, 0, 0, 16'h0, 0);
    end
    chk("reach_0010", bus.imem_addr, 16'h0010);
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 16'h0, 0);
      chk("stall_pc", bus.imem_addr, 16'h0010);
    end
    chk("stall_nopush", bus.inst_valid, 0);
    d0 = delivered;
    for (int i = 0; i < 20; i++) begin
      if (delivered != d0) break;
      cyc(0, 0, 0, 16'h0, 0);
    end
    chk("stall_deliver", last_ppt, 16'h0012);

    // halt with one queued entry and one read in flight
    do_reset(1'b0);
    lat_lo = 1;
    lat_hi = 1;
    for (int i = 0; i < 20; i++) begin
      if (accepts >= 2) break;
      cyc(0, 1, 0, 16'h0, 0);
    end
    chk("halt_setup", accepts, 2);
    cyc(0, 1, 0, 16'h0, 1);
    d0 = delivered;
    repeat (10) cyc(0, 0, 0, 16'h0, 0);
    chk("halt_delivered", delivered - d0, 2);
    chk("halt_rd", bus.imem_rd, 0);
    chk("halt_valid", bus.inst_valid, 0);
    chk("halt_nop", bus.Instruction, 16'h0800);

    // reset during a read: late done becomes a protocol error
    do_reset(1'b0);
    lat_lo = 3;
    lat_hi = 3;
    cyc(0, 1, 0, 16'h0, 0);
    do_reset(1'b1);
    repeat (6) cyc(1, 1, 0, 16'h0, 0);
    chk("err_late_done", bus.err, 1);
    repeat (2) cyc(1, 1, 0, 16'h0, 0);
    chk("err_sticky", bus.err, 1);

    // spurious done with nothing requested
    do_reset(1'b0);
    force_done = 1'b1;
    cyc(1, 1, 0, 16'h0, 0);
    force_done = 1'b0;
    chk("err_spurious", bus.err, 1);
    cyc(1, 1, 0, 16'h0, 0);
    chk("err_hold", bus.err, 1);

    // random traffic: stalls, decode backpressure, redirects
    do_reset(1'b0);
    lat_lo = 0;
    lat_hi = 3;
    for (int i = 0; i < 800; i++) begin
      r_stl = ($urandom_range(3, 0) == 0);
      r_ds  = ($urandom_range(9, 0) < 3);
      r_bj  = ($urandom_range(15, 0) == 0);
      r_tgt = 16'($urandom) & 16'hFFFE;
      if ($urandom_range(3, 0) == 0) r_tgt = 16'hFFF8;
      cyc(r_stl, r_ds, r_bj, r_tgt, 0);
    end
    chk("random_progress", delivered > 100, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
